invntt_gs_butterfly: RTL and testbench

//  Pipelined Gentleman-Sande butterfly for the Kyber-768 inverse NTT: the decode-side

---
 rtl/kyber_pkg.sv | 27 ++
 rtl/mont_reduce_reg.sv | 36 +++
 rtl/invntt_gs_butterfly.sv | 186 ++++++++++++++++++
 tb/tb_invntt_gs_butterfly.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/kyber_pkg.sv
// -----------------------------------------------------------------------------
// kyber_pkg
//   Shared Kyber arithmetic constants and types for the NTT/INTT datapaths.
//   No ports; imported by invntt_gs_butterfly and mont_reduce_reg.
//     Q        Kyber modulus
//     QINV     q^-1 mod 2^16 as a signed 16-bit value
//     BARR_V   Barrett constant round(2^26 / q)
//     SCALE_F  Montgomery-form 128^-1 used for the final INTT scaling
//     MONT_R   2^16 mod q (Montgomery form of 1)
// -----------------------------------------------------------------------------
package kyber_pkg;

    localparam int Q       = 3329;
    localparam int QINV    = -3327;
    localparam int BARR_V  = 20159;
    localparam int SCALE_F = 1441;
    localparam int MONT_R  = 2285;

    typedef logic signed [15:0] coeff_t;

    // Per-transfer operating mode of the inverse-NTT butterfly.
    typedef enum logic {
        MODE_BFLY  = 1'b0,
        MODE_SCALE = 1'b1
    } mode_e;

endpackage

// File: rtl/mont_reduce_reg.sv
// -----------------------------------------------------------------------------
// mont_reduce_reg
//   Combinational Montgomery reduction: r = (p - u*Q) >>> 16 with
//   u = low16(p * QINV) interpreted as signed. Bit-exact to the Kyber
//   reference montgomery_reduce(); result lies in (-q, q).
//   Ports:
//     p   in   32  signed product to reduce
//     r   out  16  signed reduced coefficient
// -----------------------------------------------------------------------------
module mont_reduce_reg
    import kyber_pkg::*;
(
    input  logic signed [31:0] p,
    output coeff_t             r
);

    localparam logic [15:0]        QINV16 = 16'(QINV);
    localparam logic signed [31:0] Q32    = 32'(Q);

    logic [15:0]        u_bits;
    coeff_t             u;
    logic signed [31:0] uq;
    logic signed [31:0] diff;
    logic               unused_lo;

    // Only the low 16 bits of p*QINV matter, so a 16-bit product suffices.
    assign u_bits = p[15:0] * QINV16;
    assign u      = signed'(u_bits);
    assign uq     = 32'(u) * Q32;
    assign diff   = p - uq;

    // The low half of diff is zero by construction of u.
    assign r         = diff[31:16];
    assign unused_lo = ^diff[15:0];

endmodule

// File: rtl/invntt_gs_butterfly.sv
// -----------------------------------------------------------------------------
// invntt_gs_butterfly
//   Three-stage pipelined Gentleman-Sande butterfly for the Kyber inverse NTT.
//     Butterfly mode: out_a = barrett(a + b), out_b = fqmul(zeta, b - a)
//     Scale mode:     out_a = fqmul(a, zeta), out_b = fqmul(b, zeta)
//   Valid/ready on both sides with a single global stall; the tag travels with
//   the data unmodified.
//   Ports:
//     clk        in   1      clock
//     rst        in   1      synchronous reset, active-high
//     in_valid   in   1      input transfer valid
//     in_ready   out  1      block can accept input this cycle
//     in_scale   in   1      0 = GS butterfly, 1 = scale mode
//     in_a       in   16     signed coefficient a
//     in_b       in   16     signed coefficient b
//     in_zeta    in   16     signed twiddle (Montgomery form) or scale constant
//     in_tag     in   TAG_W  sideband returned with the result
//     out_valid  out  1      result valid
//     out_ready  in   1      downstream accepts result
//     out_a      out  16     signed result a
//     out_b      out  16     signed result b
//     out_tag    out  TAG_W  tag of this result
// -----------------------------------------------------------------------------
module invntt_gs_butterfly
    import kyber_pkg::*;
#(
    parameter int TAG_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_scale,
    input  coeff_t           in_a,
    input  coeff_t           in_b,
    input  coeff_t           in_zeta,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output coeff_t           out_a,
    output coeff_t           out_b,
    output logic [TAG_W-1:0] out_tag
);

    localparam logic signed [31:0] BARR32 = 32'(BARR_V);
    localparam logic signed [31:0] RND32  = 32'sd33554432;  // 2^25
    localparam coeff_t             Q16    = 16'(Q);

    logic adv;

    // Stage 1 registers
    logic             s1_valid;
    mode_e            s1_mode;
    coeff_t           s1_sum;
    coeff_t           s1_diff;
    coeff_t           s1_zeta;
    logic [TAG_W-1:0] s1_tag;

    // Stage 2 registers
    logic               s2_valid;
    mode_e              s2_mode;
    coeff_t             s2_sum;
    logic signed [31:0] s2_pa;
    logic signed [31:0] s2_pb;
    logic [TAG_W-1:0]   s2_tag;

    // Stage 1 combinational
    mode_e  s1_mode_n;
    coeff_t s1_sum_n;
    coeff_t s1_diff_n;

    // Stage 2 combinational
    logic signed [31:0] s2_pa_n;
    logic signed [31:0] s2_pb_n;

    // Stage 3 combinational
    coeff_t           mont_a;
    coeff_t           mont_b;
    logic signed [15:0] bar_k;
    coeff_t           bar_kq;
    coeff_t           bar_a;
    coeff_t           out_a_n;

    // Global stall: everything moves only when the output slot is free.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // -------------------------------------------------------------------------
    // S1: add/subtract with int16 wrap; scale mode passes a/b straight through.
    // -------------------------------------------------------------------------
    always_comb begin
        s1_mode_n = in_scale ? MODE_SCALE : MODE_BFLY;
        s1_sum_n  = in_a + in_b;
        s1_diff_n = in_b - in_a;
        if (in_scale) begin
            s1_sum_n  = in_a;
            s1_diff_n = in_b;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_mode  <= MODE_BFLY;
            s1_sum   <= '0;
            s1_diff  <= '0;
            s1_zeta  <= '0;
            s1_tag   <= '0;
        end else if (adv) begin
            s1_valid <= in_valid;
            s1_mode  <= s1_mode_n;
            s1_sum   <= s1_sum_n;
            s1_diff  <= s1_diff_n;
            s1_zeta  <= in_zeta;
            s1_tag   <= in_tag;
        end
    end

    // -------------------------------------------------------------------------
    // S2: products. The a-path product is either the Montgomery input (scale)
    // or the rounded Barrett estimate numerator (butterfly).
    // -------------------------------------------------------------------------
    always_comb begin
        s2_pb_n = 32'(s1_zeta) * 32'(s1_diff);
        if (s1_mode == MODE_SCALE) begin
            s2_pa_n = 32'(s1_zeta) * 32'(s1_sum);
        end else begin
            s2_pa_n = BARR32 * 32'(s1_sum) + RND32;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_mode  <= MODE_BFLY;
            s2_sum   <= '0;
            s2_pa    <= '0;
            s2_pb    <= '0;
            s2_tag   <= '0;
        end else if (adv) begin
            s2_valid <= s1_valid;
            s2_mode  <= s1_mode;
            s2_sum   <= s1_sum;
            s2_pa    <= s2_pa_n;
            s2_pb    <= s2_pb_n;
            s2_tag   <= s1_tag;
        end
    end

    // -------------------------------------------------------------------------
    // S3: reductions and output register.
    // -------------------------------------------------------------------------
    mont_reduce_reg u_mont_a (
        .p (s2_pa),
        .r (mont_a)
    );

    mont_reduce_reg u_mont_b (
        .p (s2_pb),
        .r (mont_b)
    );

    // Barrett quotient k = pa >>> 26 fits in a few bits; only the low 16 bits
    // of k*Q are needed because the final subtraction wraps at 16 bits.
    always_comb begin
        bar_k   = 16'(signed'(s2_pa[31:26]));
        bar_kq  = bar_k * Q16;
        bar_a   = s2_sum - bar_kq;
        out_a_n = (s2_mode == MODE_SCALE) ? mont_a : bar_a;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_a     <= '0;
            out_b     <= '0;
            out_tag   <= '0;
        end else if (adv) begin
            out_valid <= s2_valid;
            out_a     <= out_a_n;
            out_b     <= mont_b;
            out_tag   <= s2_tag;
        end
    end

endmodule

// File: tb/tb_invntt_gs_butterfly.sv
module tb_invntt_gs_butterfly;

    localparam int TAG_W = 8;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    in_valid;
    logic                    in_ready;
    logic                    in_scale;
    logic signed [15:0]      in_a;
    logic signed [15:0]      in_b;
    logic signed [15:0]      in_zeta;
    logic [TAG_W-1:0]        in_tag;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [15:0]      out_a;
    logic signed [15:0]      out_b;
    logic [TAG_W-1:0]        out_tag;

    invntt_gs_butterfly #(.TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_scale  (in_scale),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_zeta   (in_zeta),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_a     (out_a),
        .out_b     (out_b),
        .out_tag   (out_tag)
    );

    always #5 clk = ~clk;

    typedef struct {
        int a;
        int b;
        int tag;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;
    bit   rand_ready  = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (Kyber C semantics) --------------------
    function automatic int mont(input int p);
        shortint t;
        t = shortint'(p * -3327);
        return int'(shortint'((p - int'(t) * 3329) >>> 16));
    endfunction

    function automatic int barr(input shortint a);
        int t;
        t = (20159 * int'(a) + (1 << 25)) >>> 26;
        return int'(shortint'(int'(a) - t * 3329));
    endfunction

    task automatic model(input shortint a, input shortint b, input shortint z, input bit sc,
                         output int ea, output int eb);
        shortint s, d;
        if (sc) begin
            ea = mont(int'(a) * int'(z));
            eb = mont(int'(b) * int'(z));
        end else begin
            s  = shortint'(int'(a) + int'(b));
            d  = shortint'(int'(b) - int'(a));
            ea = barr(s);
            eb = mont(int'(z) * int'(d));
        end
    endtask

    // ---------------- driver -------------------------------------------------
    task automatic send(input shortint a, input shortint b, input shortint z, input bit sc,
                        input logic [7:0] tag, input int ea, input int eb);
        bit acc;
        exp_t e;
        acc      = 1'b0;
        in_a     = a;
        in_b     = b;
        in_zeta  = z;
        in_scale = sc;
        in_tag   = tag;
        in_valid = 1'b1;
        for (int i = 0; i < 300 && !acc; i++) begin
            @(negedge clk);
            if (in_ready) begin
                acc   = 1'b1;
                e.a   = ea;
                e.b   = eb;
                e.tag = int'(tag);
                sb.push_back(e);
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!acc) chk("send_timeout", 0, 1);
    endtask

    task automatic send_rand(input logic [7:0] tag);
        shortint a, b, z;
        bit      sc;
        int      ea, eb;
        a  = shortint'($urandom);
        b  = shortint'($urandom);
        if ($urandom_range(0, 3) == 0) z = shortint'($urandom);
        else z = shortint'(int'($urandom_range(0, 6656)) - 3328);
        sc = ($urandom_range(0, 3) == 0);
        model(a, b, z, sc, ea, eb);
        send(a, b, z, sc, tag, ea, eb);
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 1000 && sb.size() != 0; i++) @(posedge clk);
        #1;
        chk(name, sb.size(), 0);
    endtask

    // ---------------- random backpressure ------------------------------------
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (rand_ready) out_ready = ($urandom_range(0, 2) != 0);
        end
    end

    // ---------------- monitor / scoreboard -----------------------------------
    initial begin
        bit               hold;
        int               ha, hb, ht;
        exp_t             e;
        hold = 1'b0;
        ha = 0; hb = 0; ht = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold = 1'b0;
                continue;
            end
            if (hold) begin
                chk("hold_valid", int'(out_valid), 1);
                chk("hold_a", int'(out_a), ha);
                chk("hold_b", int'(out_b), hb);
                chk("hold_tag", int'(out_tag), ht);
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_output", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("out_tag", int'(out_tag), e.tag);
                    chk("out_a", int'(out_a), e.a);
                    chk("out_b", int'(out_b), e.b);
                end
            end
            hold = out_valid && !out_ready;
            ha   = int'(out_a);
            hb   = int'(out_b);
            ht   = int'(out_tag);
        end
    end

    // ---------------- watchdog -----------------------------------------------
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "simulation did not finish");
    end

    // ---------------- main sequence ------------------------------------------
    initial begin
        int n;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_scale  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_zeta   = '0;
        in_tag    = '0;
        out_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_a", int'(out_a), 0);
        chk("rst_out_b", int'(out_b), 0);
        chk("rst_out_tag", int'(out_tag), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", int'(in_ready), 1);
        @(posedge clk);
        #1;

        // Directed vectors and latency
        send(16'sd1, 16'sd2, 16'sd2285, 1'b0, 8'h11, 3, 1);
        n = 1;
        while (!out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("latency", n, 3);
        wait_drain("drain_d1");
        send(16'sd3000, 16'sd1000, 16'sd2285, 1'b0, 8'h5A, 671, 1329);
        send(16'sd1, -16'sd1, 16'sd1441, 1'b1, 8'hC3, 512, -512);
        wait_drain("drain_directed");

        // Random traffic with random backpressure
        rand_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                @(posedge clk);
                #1;
            end
            send_rand(8'(i));
        end
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        wait_drain("drain_random");

        // Full pipeline held for 5 clocks
        out_ready = 1'b0;
        send_rand(8'hA0);
        send_rand(8'hA1);
        send_rand(8'hA2);
        in_a     = 16'sd7;
        in_b     = 16'sd9;
        in_zeta  = 16'sd2285;
        in_scale = 1'b0;
        in_tag   = 8'hEE;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_in_ready", int'(in_ready), 0);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        send_rand(8'hA3);
        wait_drain("drain_stall");

        // Reset with two items in flight
        send_rand(8'hB0);
        send_rand(8'hB1);
        rst = 1'b1;
        sb.delete();
        @(posedge clk);
        #1;
        chk("midrst_out_valid", int'(out_valid), 0);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("no_stale_output", int'(out_valid), 0);
        end
        @(posedge clk);
        #1;
        send(16'sd3000, 16'sd1000, 16'sd2285, 1'b0, 8'h77, 671, 1329);
        wait_drain("drain_post_reset");

        repeat (4) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
